// File: rtl/dac_update_scheduler.sv
`timescale 1ns/1ps
// Per-frame DAC update scheduler: captures per-DAC channel requests, arbitrates the shared
// HPF/threshold datapath round-robin between two DACs, then kicks the selected DAC's SPI shift.

module dac_update_scheduler #(
  parameter int unsigned NUM_CH      = 35,
  parameter int unsigned DP_TIMEOUT  = 64,
  parameter int unsigned SPI_TIMEOUT = 128
) (
  input  logic       dataclk,
  input  logic       reset,
  input  logic       SPI_start,
  input  logic [5:0] channel,
  input  logic       ch_valid,
  input  logic [1:0] DAC_en,
  input  logic [5:0] DAC_sel_1,
  input  logic [5:0] DAC_sel_2,
  output logic       dp_start,
  output logic       dp_dac_idx,
  input  logic       dp_done,
  output logic [1:0] spi_start,
  input  logic [1:0] spi_done,
  output logic [1:0] pending,
  output logic [1:0] overrun,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic       frame_done,
  output logic [2:0] sched_state
);

  localparam int unsigned CH_W   = 6;
  localparam int unsigned MAX_TO = (DP_TIMEOUT > SPI_TIMEOUT) ? DP_TIMEOUT : SPI_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(MAX_TO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DP_LIM  = CNT_W'(DP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SPI_LIM = CNT_W'(SPI_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_DP  = 3'd2,
    S_SPI      = 3'd3,
    S_WAIT_SPI = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             idx_q, idx_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       ovr_q, ovr_d;
  logic [1:0]       rq_q, rq_d;
  logic [1:0]       spi_q, spi_d;
  logic             terr_q, terr_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;
  logic [1:0]       req, clr, inflight;

  assign req[0]   = ch_valid & SPI_start & DAC_en[0] & (channel == DAC_sel_1);
  assign req[1]   = ch_valid & SPI_start & DAC_en[1] & (channel == DAC_sel_2);
  assign inflight = (state_q == S_IDLE) ? 2'b00 : (idx_q ? 2'b10 : 2'b01);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      rq_q    <= '0;
      spi_q   <= '0;
      terr_q  <= 1'b0;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      rq_q    <= rq_d;
      spi_q   <= spi_d;
      terr_q  <= terr_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    rq_d    = rq_q;
    spi_d   = 2'b00;
    terr_d  = terr_q;
    dp_d    = 1'b0;
    clr     = 2'b00;
    frame_d = ch_valid & (channel == LAST_CH);

    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          idx_d   = (&pend_q) ? ~last_q : pend_q[1];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_DP;
      end
      S_WAIT_DP: begin
        if (dp_done) begin
          state_d = S_SPI;
        end else if (cnt_q >= DP_LIM) begin
          terr_d     = 1'b1;
          clr[idx_q] = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SPI: begin
        spi_d[idx_q] = 1'b1;
        clr[idx_q]   = 1'b1;
        cnt_d        = '0;
        state_d      = S_WAIT_SPI;
      end
      S_WAIT_SPI: begin
        if (spi_done[idx_q]) begin
          last_d  = idx_q;
          state_d = S_IDLE;
        end else if (cnt_q >= SPI_LIM) begin
          terr_d  = 1'b1;
          last_d  = idx_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request landing while its own DAC is in flight is kept so the pending clear cannot drop it.
    for (int k = 0; k < 2; k++) begin
      if (clr[k]) rq_d[k] = 1'b0;
      if (req[k]) begin
        pend_d[k] = 1'b1;
        if (pend_q[k] && !clr[k]) begin
          ovr_d[k] = 1'b1;
          if (inflight[k]) rq_d[k] = 1'b1;
        end
      end else if (clr[k]) begin
        pend_d[k] = rq_q[k] & DAC_en[k];
      end else if (!DAC_en[k] && !inflight[k]) begin
        pend_d[k] = 1'b0;
      end
    end

    if (err_clr) begin
      ovr_d  = 2'b00;
      terr_d = 1'b0;
    end
  end

  assign dp_start    = dp_q;
  assign dp_dac_idx  = idx_q;
  assign spi_start   = spi_q;
  assign pending     = pend_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;
  assign frame_done  = frame_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
`timescale 1ns/1ps
// Bench for dac_update_scheduler: directed scenarios plus a randomized phase, every cycle
// compared against a transaction-level reference of the scheduling rules.

module tb_dac_update_scheduler;

  localparam int NUM_CH      = 35;
  localparam int DP_TIMEOUT  = 64;
  localparam int SPI_TIMEOUT = 128;
  localparam int IDLE = 0, ISSUE = 1, WAIT_DP = 2, SPI = 3, WAIT_SPI = 4;

  logic       dataclk = 1'b0;
  logic       reset, SPI_start, ch_valid, dp_done, err_clr;
  logic [5:0] channel, DAC_sel_1, DAC_sel_2;
  logic [1:0] DAC_en, spi_done;
  logic       dp_start, dp_dac_idx, timeout_err, frame_done;
  logic [1:0] spi_start, pending, overrun;
  logic [2:0] sched_state;

  always #5 dataclk = ~dataclk;

  dac_update_scheduler #(.NUM_CH(NUM_CH), .DP_TIMEOUT(DP_TIMEOUT), .SPI_TIMEOUT(SPI_TIMEOUT)) dut (
    .dataclk(dataclk), .reset(reset), .SPI_start(SPI_start), .channel(channel),
    .ch_valid(ch_valid), .DAC_en(DAC_en), .DAC_sel_1(DAC_sel_1), .DAC_sel_2(DAC_sel_2),
    .dp_start(dp_start), .dp_dac_idx(dp_dac_idx), .dp_done(dp_done), .spi_start(spi_start),
    .spi_done(spi_done), .pending(pending), .overrun(overrun), .timeout_err(timeout_err),
    .err_clr(err_clr), .frame_done(frame_done), .sched_state(sched_state)
  );

  int n_vec = 0, n_bad = 0;

  // Reference: current service phase, served DAC, elapsed wait, queued/overrun/error flags.
  int       m_phase, m_wait;
  bit       m_idx, m_last, m_terr, m_dp, m_frame;
  bit [1:0] m_pend, m_ovr, m_late, m_spi;

  int       dp_lat, spi_lat, dp_cnt, spi_cnt;
  bit       spi_k;
  logic [1:0] spi_log[$];

  function automatic void model_reset();
    m_phase = IDLE; m_wait = 0; m_idx = 0; m_last = 1; m_terr = 0; m_dp = 0; m_frame = 0;
    m_pend = 0; m_ovr = 0; m_late = 0; m_spi = 0;
  endfunction

  function automatic void model_step();
    bit [5:0] sel[2];
    bit [1:0] req, drop, busy;
    int       nphase = m_phase, nwait = m_wait;
    bit       nidx = m_idx, nlast = m_last, nterr = m_terr;
    bit [1:0] npend = m_pend, novr = m_ovr, nlate = m_late;
    sel[0] = DAC_sel_1; sel[1] = DAC_sel_2;
    drop = 0;
    m_dp = 0; m_spi = 0;
    for (int k = 0; k < 2; k++) begin
      req[k]  = ch_valid && SPI_start && DAC_en[k] && (channel == sel[k]);
      busy[k] = (m_phase != IDLE) && (int'(m_idx) == k);
    end
    if (m_phase == IDLE && m_pend != 0) begin
      nidx   = (m_pend == 2'b11) ? !m_last : m_pend[1];
      nphase = ISSUE;
    end else if (m_phase == ISSUE) begin
      m_dp = 1; nwait = 0; nphase = WAIT_DP;
    end else if (m_phase == WAIT_DP) begin
      if (dp_done) nphase = SPI;
      else if (m_wait + 1 >= DP_TIMEOUT) begin nterr = 1; drop[m_idx] = 1; nphase = IDLE; end
      else nwait = m_wait + 1;
    end else if (m_phase == SPI) begin
      m_spi[m_idx] = 1; drop[m_idx] = 1; nwait = 0; nphase = WAIT_SPI;
    end else if (m_phase == WAIT_SPI) begin
      if (spi_done[m_idx]) begin nlast = m_idx; nphase = IDLE; end
      else if (m_wait + 1 >= SPI_TIMEOUT) begin nterr = 1; nlast = m_idx; nphase = IDLE; end
      else nwait = m_wait + 1;
    end
    for (int k = 0; k < 2; k++) begin
      if (drop[k]) nlate[k] = 0;
      if (req[k]) begin
        npend[k] = 1;
        if (m_pend[k] && !drop[k]) begin novr[k] = 1; if (busy[k]) nlate[k] = 1; end
      end else if (drop[k]) npend[k] = m_late[k] & DAC_en[k];
      else if (!DAC_en[k] && !busy[k]) npend[k] = 0;
    end
    if (err_clr) begin novr = 0; nterr = 0; end
    m_frame = ch_valid && (int'(channel) == NUM_CH - 1);
    m_phase = nphase; m_wait = nwait; m_idx = nidx; m_last = nlast; m_terr = nterr;
    m_pend = npend; m_ovr = novr; m_late = nlate;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("dp_start", dp_start, m_dp);
    check("dp_dac_idx", dp_dac_idx, m_idx);
    check("spi_start", spi_start, m_spi);
    check("pending", pending, m_pend);
    check("overrun", overrun, m_ovr);
    check("timeout_err", timeout_err, m_terr);
    check("frame_done", frame_done, m_frame);
    check("sched_state", sched_state, m_phase);
  endtask

  // One clock: step the reference, sample outputs after the edge, then act as datapath/SPI.
  task automatic tick();
    model_step();
    @(posedge dataclk); #1;
    check_all();
    if (spi_start != 2'b00) spi_log.push_back(spi_start);
    ch_valid = 0; err_clr = 0; dp_done = 0; spi_done = 2'b00;
    if (dp_cnt > 0) begin dp_cnt--; if (dp_cnt == 0) dp_done = 1; end
    if (m_dp && dp_lat > 0) dp_cnt = dp_lat;
    if (spi_cnt > 0) begin spi_cnt--; if (spi_cnt == 0) spi_done[spi_k] = 1; end
    if (m_spi != 0 && spi_lat > 0) begin spi_cnt = spi_lat; spi_k = m_spi[1]; end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_phase != IDLE || m_pend != 0) && n < budget) begin tick(); n++; end
    check("idle_budget", 32'(n >= budget), 0);
  endtask

  task automatic pulse_ch(input logic [5:0] ch);
    channel = ch; ch_valid = 1; tick();
  endtask

  initial begin
    int n;
    reset = 0; SPI_start = 1; ch_valid = 0; dp_done = 0; err_clr = 0; channel = 0;
    DAC_sel_1 = 0; DAC_sel_2 = 0; DAC_en = 0; spi_done = 0;
    dp_lat = 3; spi_lat = 4; dp_cnt = 0; spi_cnt = 0; spi_k = 0;
    model_reset();
    #22 reset = 1;
    check_all();

    // Tie on a shared channel: DAC 1 first, then DAC 2; the following tie again starts with DAC 1.
    DAC_en = 2'b11; DAC_sel_1 = 7; DAC_sel_2 = 7;
    spi_log.delete(); pulse_ch(7); wait_idle(300);
    check("tie_count", spi_log.size(), 2);
    check("tie_first", spi_log[0], 2'b01);
    check("tie_second", spi_log[1], 2'b10);
    spi_log.delete(); pulse_ch(7); wait_idle(300);
    check("tie2_first", spi_log[0], 2'b01);

    // Single DAC path with exact request-to-datapath latency.
    DAC_en = 2'b01; DAC_sel_1 = 5; DAC_sel_2 = 30; dp_lat = 4; spi_lat = 10;
    spi_log.delete(); pulse_ch(5); tick(); tick();
    check("lat3_dp_start", dp_start, 1);
    check("lat3_idx", dp_dac_idx, 0);
    wait_idle(300);
    check("single_spi", spi_log[0], 2'b01);
    check("single_pending", pending, 2'b00);
    check("single_errs", {overrun, timeout_err}, 3'b000);

    // Overrun: second request during a long datapath wait survives the SPI clear.
    DAC_sel_1 = 20; dp_lat = 40; spi_lat = 6;
    pulse_ch(20);
    repeat (12) tick();
    pulse_ch(20);
    n = 0;
    while (spi_start == 2'b00 && n < 100) begin tick(); n++; end
    check("ovr_spi_seen", spi_start, 2'b01);
    check("ovr_pending0", pending[0], 1);
    check("ovr_flag0", overrun[0], 1);
    wait_idle(400);
    err_clr = 1; tick();
    check("ovr_cleared", overrun, 2'b00);

    // Datapath timeout: no dp_done ever.
    DAC_sel_1 = 11; dp_lat = 0; spi_log.delete();
    pulse_ch(11);
    n = 0;
    while (dp_start !== 1'b1 && n < 10) begin tick(); n++; end
    check("to_dp_seen", dp_start, 1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin tick(); n++; end
    check("to_latency", n, DP_TIMEOUT);
    check("to_no_spi", spi_log.size(), 0);
    check("to_state", sched_state, IDLE);
    check("to_pending0", pending[0], 0);
    err_clr = 1; tick();
    check("to_cleared", timeout_err, 0);

    // Gating: run enable low, enable dropped for a waiting DAC, frame marker.
    dp_lat = 5; spi_lat = 3; SPI_start = 0; DAC_sel_1 = 5;
    pulse_ch(5); tick();
    check("gate_no_req", pending, 2'b00);
    SPI_start = 1; DAC_en = 2'b11; DAC_sel_1 = 3; DAC_sel_2 = 9; spi_log.delete();
    pulse_ch(3); pulse_ch(9); tick();
    DAC_en = 2'b01; tick();
    check("gate_drop_pend", pending, 2'b01);
    wait_idle(300);
    check("gate_only_dac1", spi_log.size(), 1);
    check("gate_dac1_spi", spi_log[0], 2'b01);
    pulse_ch(6'(NUM_CH - 1));
    check("frame_pulse", frame_done, 1);
    tick();
    check("frame_one_cycle", frame_done, 0);

    // Randomized traffic with stray handshake strobes.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom % 3);
      if ($urandom % 150 == 0) DAC_en = 2'($urandom);
      if ($urandom % 200 == 0) begin
        DAC_sel_1 = 6'($urandom_range(0, 34)); DAC_sel_2 = 6'($urandom_range(0, 34));
      end
      SPI_start = ($urandom % 8) != 0;
      dp_lat  = ($urandom % 25 == 0) ? 0 : int'($urandom_range(1, 12));
      spi_lat = ($urandom % 40 == 0) ? 0 : int'($urandom_range(1, 20));
      if ($urandom % 5 == 0) begin
        ch_valid = 1;
        channel = (r == 0) ? DAC_sel_1 : (r == 1) ? DAC_sel_2 : 6'($urandom_range(0, 40));
      end
      if ($urandom % 60 == 0) err_clr = 1;
      if ($urandom % 40 == 0) dp_done = 1;
      if ($urandom % 40 == 0) spi_done = spi_done | 2'($urandom);
      tick();
    end
    SPI_start = 1; err_clr = 1; dp_lat = 3; spi_lat = 4; tick();
    wait_idle(2000);

    // Asynchronous reset in the middle of an SPI wait.
    DAC_en = 2'b01; DAC_sel_1 = 5; dp_lat = 2; spi_lat = 0;
    pulse_ch(5);
    n = 0;
    while (m_phase != WAIT_SPI && n < 20) begin tick(); n++; end
    check("rst_reached_wait_spi", sched_state, WAIT_SPI);
    #3 reset = 0;
    #1;
    check("rst_dp_start", dp_start, 0);
    check("rst_idx", dp_dac_idx, 0);
    check("rst_spi_start", spi_start, 2'b00);
    check("rst_pending", pending, 2'b00);
    check("rst_overrun", overrun, 2'b00);
    check("rst_timeout", timeout_err, 0);
    check("rst_frame", frame_done, 0);
    check("rst_state", sched_state, IDLE);
    model_reset();
    dp_cnt = 0; spi_cnt = 0; dp_done = 0; spi_done = 0; ch_valid = 0; err_clr = 0;
    #10 reset = 1;
    DAC_en = 2'b11; DAC_sel_1 = 12; DAC_sel_2 = 12; dp_lat = 3; spi_lat = 4;
    spi_log.delete(); pulse_ch(12); wait_idle(300);
    check("post_rst_tie", spi_log[0], 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
